// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debounce stage.
// Holds the debounce FSM state encoding and default parameter values.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'b00,
    CHK_HIGH    = 2'b01,
    HIGH_STABLE = 2'b10,
    CHK_LOW     = 2'b11
  } db_state_t;

  localparam int unsigned DB_STABLE_CYCLES_DEF = 50000;
  localparam int unsigned DB_CNT_W_DEF         = 16;
  localparam int unsigned DB_GLITCH_W_DEF      = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronised out).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic q_d, q_q;

  always_comb begin
    s1_d = d;
    q_d  = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      q_q  <= 1'b0;
    end else begin
      s1_q <= s1_d;
      q_q  <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/debounce_edge.sv
// Synchronise, debounce and edge-detect a raw switch/button input.
// Ports: clk, reset (sync, active-high), d (raw), out (clean level),
//        rise/fall (1-cycle pulses), glitch_cnt (saturating abort count).
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = DB_CNT_W_DEF,
  parameter int unsigned GLITCH_W      = DB_GLITCH_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                d,
  output logic                out,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam longint unsigned CNT_MAX =
    (64'd1 << CNT_W) - 64'd1;

  if (STABLE_CYCLES < 2 ||
      64'(STABLE_CYCLES) > CNT_MAX) begin : g_param_check
    $error("debounce_edge: STABLE_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic s;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (s)
  );

  db_state_t state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic out_d, out_q;
  logic rise_d, rise_q;
  logic fall_d, fall_q;
  logic [GLITCH_W-1:0] glitch_d, glitch_q;
  logic glitch_inc;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    unique case (state_q)
      LOW_STABLE: begin
        if (s) begin
          state_d = CHK_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CHK_HIGH: begin
        if (!s) begin
          state_d    = LOW_STABLE;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH_STABLE: begin
        if (!s) begin
          state_d = CHK_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CHK_LOW: begin
        if (s) begin
          state_d    = HIGH_STABLE;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
          out_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturate rather than wrap so a stuck-bouncing input stays visible.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_inc && glitch_q != GLITCH_MAX) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOW_STABLE;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign out        = out_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge (STABLE_CYCLES=4, GLITCH_W=3).
// Vector table, directed corner sequences and random stimulus vs a model.
module tb_debounce_edge;

  localparam int S  = 4;
  localparam int CW = 3;
  localparam int GW = 3;
  localparam int GMAX = (1 << GW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic d;
  logic out, rise, fall;
  logic [GW-1:0] glitch_cnt;

  always #5 clk = ~clk;

  debounce_edge #(
    .STABLE_CYCLES (S),
    .CNT_W         (CW),
    .GLITCH_W      (GW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .out        (out),
    .rise       (rise),
    .fall       (fall),
    .glitch_cnt (glitch_cnt)
  );

  int checks = 0;
  int failures = 0;
  int rise_seen = 0;
  int fall_seen = 0;

  // Model: synchroniser delay plus "last S synchronised samples all
  // differ from out" rule; a glitch is a return to out's level right
  // after a sample that differed from it.
  bit m_p0, m_p1, m_prev, m_out, m_rise, m_fall;
  int m_gl;
  bit hist[$];

  typedef struct {
    bit d;
    bit rst;
    bit out;
    bit rise;
    bit fall;
    int gl;
  } vec_t;

  vec_t tv[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(bit di, bit ri);
    bit sn;
    bit all_diff;
    if (ri) begin
      m_p0 = 0; m_p1 = 0; m_prev = 0;
      m_out = 0; m_rise = 0; m_fall = 0;
      m_gl = 0;
      hist.delete();
    end else begin
      sn = m_p1;
      m_p1 = m_p0;
      m_p0 = di;
      m_rise = 0;
      m_fall = 0;
      if (sn == m_out && m_prev != m_out && m_gl < GMAX)
        m_gl++;
      hist.push_back(sn);
      if (hist.size() > S) void'(hist.pop_front());
      if (hist.size() == S) begin
        all_diff = 1;
        foreach (hist[i]) if (hist[i] == m_out) all_diff = 0;
        if (all_diff) begin
          m_out = !m_out;
          if (m_out) m_rise = 1;
          else m_fall = 1;
        end
      end
      m_prev = sn;
    end
  endtask

  task automatic step(bit di, bit ri);
    @(negedge clk);
    d = di;
    reset = ri;
    @(posedge clk);
    model_edge(di, ri);
    #1;
    if (rise === 1'b1) rise_seen++;
    if (fall === 1'b1) fall_seen++;
    chk("out", out, m_out);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("glitch_cnt", glitch_cnt, m_gl);
    chk("rise_fall_excl", rise & fall, 0);
  endtask

  task automatic add(bit di, bit ri, bit o, bit r, bit f, int g);
    vec_t v;
    v.d = di; v.rst = ri; v.out = o;
    v.rise = r; v.fall = f; v.gl = g;
    tv.push_back(v);
  endtask

  initial begin
    int rs0, gl0;
    reset = 1'b1;
    d = 1'b0;

    // Reset held with d=1, then clean rise, clean fall, short pulse.
    repeat (3) add(1, 1, 0, 0, 0, 0);
    repeat (5) add(1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0);
    repeat (2) add(1, 0, 1, 0, 0, 0);
    repeat (5) add(0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0);
    repeat (3) add(1, 0, 0, 0, 0, 0);
    repeat (2) add(0, 0, 0, 0, 0, 0);
    repeat (2) add(0, 0, 0, 0, 0, 1);

    foreach (tv[i]) begin
      step(tv[i].d, tv[i].rst);
      chk($sformatf("tv%0d_out", i), out, tv[i].out);
      chk($sformatf("tv%0d_rise", i), rise, tv[i].rise);
      chk($sformatf("tv%0d_fall", i), fall, tv[i].fall);
      chk($sformatf("tv%0d_gl", i), glitch_cnt, tv[i].gl);
    end

    // Bounce: excursions one cycle too short, repeated past saturation.
    rs0 = rise_seen;
    for (int k = 0; k < 10; k++) begin
      repeat (S - 1) step(1, 0);
      step(0, 0);
    end
    repeat (3) step(0, 0);
    chk("bounce_gl_sat", glitch_cnt, GMAX);
    chk("bounce_no_rise", rise_seen - rs0, 0);
    chk("bounce_out", out, 0);

    // Threshold: 5 high samples, then the minimum 4, then a short 3.
    step(0, 1);
    for (int t = 0; t < 14; t++) begin
      step(t < 5, 0);
      chk($sformatf("thr5_rise_t%0d", t), rise, t == 5);
      chk($sformatf("thr5_fall_t%0d", t), fall, t == 10);
    end
    for (int t = 0; t < 12; t++) begin
      step(t < S, 0);
      chk($sformatf("thr4_rise_t%0d", t), rise, t == 5);
      chk($sformatf("thr4_fall_t%0d", t), fall, t == 9);
    end
    gl0 = int'(glitch_cnt);
    rs0 = rise_seen;
    repeat (S - 1) step(1, 0);
    repeat (4) step(0, 0);
    chk("short_hi_gl", glitch_cnt, gl0 + 1);
    chk("short_hi_no_rise", rise_seen - rs0, 0);
    chk("short_hi_out", out, 0);

    // Short low excursion from a high level.
    repeat (8) step(1, 0);
    gl0 = int'(glitch_cnt);
    rs0 = fall_seen;
    repeat (S - 1) step(0, 0);
    repeat (4) step(1, 0);
    chk("short_lo_gl", glitch_cnt, gl0 + 1);
    chk("short_lo_no_fall", fall_seen - rs0, 0);
    chk("short_lo_out", out, 1);

    // Reset in the middle of a rising check (cnt == 3).
    step(0, 1);
    repeat (3) step(0, 0);
    repeat (5) step(1, 0);
    step(1, 1);
    chk("rst_mid_out", out, 0);
    chk("rst_mid_rise", rise, 0);
    chk("rst_mid_gl", glitch_cnt, 0);
    for (int r = 0; r < 8; r++) begin
      step(1, 0);
      chk($sformatf("rst_restart_rise_r%0d", r), rise, r == 5);
      chk($sformatf("rst_restart_gl_r%0d", r), glitch_cnt, 0);
    end

    // Random runs of varying length with occasional resets.
    for (int n = 0; n < 600; n++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        step(lvl, $urandom_range(0, 199) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
